// File: rtl/weight_load_ctrl_if.sv
// Bundle between the weight-load sequencer, the shared weight memory port and
// the weight-load pipeline register. The DUT side uses the slave modport.
interface weight_load_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              START;
  logic [ADDR_W-1:0] BASE_ADDR;
  logic [4:0]        SHAMT_CFG;
  // Memory handshake: WM_REQ/WM_ADDR is the offer and stays stable until a
  // cycle with WM_REQ & WM_GNT; that cycle is the transfer. WM_GNT seen with
  // WM_REQ low means nothing. WM_RVALID/WM_RDATA returns the word for the one
  // outstanding read at least one cycle after the grant and cannot be stalled.
  logic              WM_REQ;
  logic [ADDR_W-1:0] WM_ADDR;
  logic              WM_GNT;
  logic              WM_RVALID;
  logic [31:0]       WM_RDATA;
  logic              WLoad1;
  logic [31:0]       WDATA1;
  logic [4:0]        shamt1;
  logic [1:0]        WROW1;
  logic              BUSY;
  logic              DONE;

  modport slave (
    input  START, BASE_ADDR, SHAMT_CFG, WM_GNT, WM_RVALID, WM_RDATA,
    output WM_REQ, WM_ADDR, WLoad1, WDATA1, shamt1, WROW1, BUSY, DONE
  );

  modport master (
    output START, BASE_ADDR, SHAMT_CFG, WM_GNT, WM_RVALID, WM_RDATA,
    input  WM_REQ, WM_ADDR, WLoad1, WDATA1, shamt1, WROW1, BUSY, DONE
  );
endinterface

// File: rtl/weight_load_ctrl.sv
// Fetches ROWS weight rows, one outstanding read at a time, and forwards each
// returned word as a one-cycle load pulse into the MAC weight pipeline register.
module weight_load_ctrl #(
  parameter int ADDR_W = 10,
  parameter int ROWS   = 4,
  parameter int STRIDE = 1
) (
  input  logic              CLK,
  input  logic              RSTN,
  weight_load_ctrl_if.slave bus,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] next_addr;
  logic [4:0]        shamt_q, shamt_d;
  logic [4:0]        shamt1_q, shamt1_d;
  logic [1:0]        row_q, row_d;
  logic [1:0]        wrow_q, wrow_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              req_q, req_d;
  logic              wload_q, wload_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              grant;
  logic              rvalid;

  assign grant  = req_q & bus.WM_GNT;
  assign rvalid = (state_q == S_WAIT) & bus.WM_RVALID;
  // Address of the row after row_q; wraps modulo 2^ADDR_W by truncation.
  assign next_addr = base_q + ADDR_W'(32'(row_q + 2'd1) * STRIDE);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.START) state_d = S_REQ;
      S_REQ:   if (grant) state_d = S_WAIT;
      S_WAIT:  if (rvalid) state_d = (row_q == LAST_ROW) ? S_IDLE : S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    base_d   = base_q;
    addr_d   = addr_q;
    shamt_d  = shamt_q;
    shamt1_d = shamt1_q;
    row_d    = row_q;
    wrow_d   = wrow_q;
    wdata_d  = wdata_q;
    req_d    = req_q;
    wload_d  = 1'b0;
    done_d   = 1'b0;
    busy_d   = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          base_d  = bus.BASE_ADDR;
          shamt_d = bus.SHAMT_CFG;
          row_d   = 2'd0;
          req_d   = 1'b1;
          addr_d  = bus.BASE_ADDR;
        end
      end
      S_REQ: begin
        if (grant) req_d = 1'b0;
      end
      S_WAIT: begin
        if (rvalid) begin
          wload_d  = 1'b1;
          wdata_d  = bus.WM_RDATA;
          wrow_d   = row_q;
          shamt1_d = shamt_q;
          // The next request goes out in the same cycle as this load pulse.
          if (row_q != LAST_ROW) begin
            row_d  = row_q + 2'd1;
            req_d  = 1'b1;
            addr_d = next_addr;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      base_q   <= '0;
      addr_q   <= '0;
      shamt_q  <= '0;
      shamt1_q <= '0;
      row_q    <= '0;
      wrow_q   <= '0;
      wdata_q  <= '0;
      req_q    <= 1'b0;
      wload_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      base_q   <= base_d;
      addr_q   <= addr_d;
      shamt_q  <= shamt_d;
      shamt1_q <= shamt1_d;
      row_q    <= row_d;
      wrow_q   <= wrow_d;
      wdata_q  <= wdata_d;
      req_q    <= req_d;
      wload_q  <= wload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.WM_REQ   = req_q;
  assign bus.WM_ADDR  = addr_q;
  assign bus.WLoad1   = wload_q;
  assign bus.WDATA1   = wdata_q;
  assign bus.shamt1   = shamt1_q;
  assign bus.WROW1    = wrow_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Bench for weight_load_ctrl: a memory responder with per-row grant/read
// delays, a load monitor, and one task per scenario checked against a model.
module tb_weight_load_ctrl;
  localparam int ADDR_W = 10;
  localparam int ROWS   = 4;
  localparam int STRIDE = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  weight_load_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  weight_load_ctrl #(.ADDR_W(ADDR_W), .ROWS(ROWS), .STRIDE(STRIDE)) dut (
    .CLK        (clk),
    .RSTN       (rst_n),
    .bus        (bus.slave),
    .dbg_state_o(dbg_state)
  );

  // Responder knobs and state
  int          gnt_dly[4];
  int          rv_dly[4];
  int          resp_idx = 0;
  bit          req_seen = 0;
  int          gnt_wait = 0;
  bit          rv_pend = 0;
  int          rv_wait = 0;
  logic [31:0] rv_data = '0;
  bit          data_fixed = 0;
  bit          spur_rv = 0;
  bit          spur_gnt = 0;
  int          stall_err = 0;
  logic        prev_req = 1'b0;
  logic        prev_gnt = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  int          start_ref = 0;

  // Observations and expected read data
  logic [ADDR_W-1:0] gnt_addr_q[$];
  logic [31:0]       exp_q[$];
  int                rv_rel_q[$];
  logic [31:0]       ld_data_q[$];
  logic [1:0]        ld_row_q[$];
  logic [4:0]        ld_shamt_q[$];
  int                ld_rel_q[$];
  int                done_rel_q[$];
  logic              busy_arr[64];

  // Memory responder, driven on the falling edge
  initial begin
    bus.WM_GNT = 1'b0;
    bus.WM_RVALID = 1'b0;
    bus.WM_RDATA = '0;
    forever begin
      @(negedge clk);
      if (rst_n && prev_req && !prev_gnt &&
          (bus.WM_REQ !== 1'b1 || bus.WM_ADDR !== prev_addr)) stall_err++;
      bus.WM_GNT = 1'b0;
      bus.WM_RVALID = 1'b0;
      if (rv_pend) begin
        if (rv_wait == 0) begin
          bus.WM_RVALID = 1'b1;
          bus.WM_RDATA = rv_data;
          exp_q.push_back(rv_data);
          rv_rel_q.push_back(cyc - start_ref);
          rv_pend = 0;
        end else begin
          rv_wait--;
        end
      end
      if (bus.WM_REQ === 1'b1) begin
        if (!req_seen) begin
          req_seen = 1;
          gnt_wait = gnt_dly[resp_idx % 4];
        end
        if (gnt_wait == 0) begin
          bus.WM_GNT = 1'b1;
          gnt_addr_q.push_back(bus.WM_ADDR);
          rv_data = data_fixed ? 32'hA0 + 32'(resp_idx % ROWS) : $urandom();
          rv_pend = 1;
          rv_wait = rv_dly[resp_idx % 4] - 1;
          resp_idx++;
          req_seen = 0;
        end else begin
          gnt_wait--;
        end
      end
      if (spur_gnt && bus.WM_REQ !== 1'b1) bus.WM_GNT = 1'b1;
      if (spur_rv && !bus.WM_RVALID) begin
        bus.WM_RVALID = 1'b1;
        bus.WM_RDATA = 32'hDEAD_0000 | $urandom_range(0, 255);
      end
      prev_req = bus.WM_REQ;
      prev_gnt = bus.WM_GNT;
      prev_addr = bus.WM_ADDR;
    end
  end

  // Load/DONE/BUSY monitor, sampled just after the rising edge
  initial begin
    int rel;
    forever begin
      @(posedge clk);
      #1;
      rel = cyc - start_ref;
      if (rel >= 0 && rel < 64) busy_arr[rel] = bus.BUSY;
      if (bus.WLoad1 === 1'b1) begin
        ld_data_q.push_back(bus.WDATA1);
        ld_row_q.push_back(bus.WROW1);
        ld_shamt_q.push_back(bus.shamt1);
        ld_rel_q.push_back(rel);
      end
      if (bus.DONE === 1'b1) done_rel_q.push_back(rel);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    gnt_addr_q.delete(); exp_q.delete(); rv_rel_q.delete();
    ld_data_q.delete(); ld_row_q.delete(); ld_shamt_q.delete(); ld_rel_q.delete();
    done_rel_q.delete();
    for (int i = 0; i < 64; i++) busy_arr[i] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gnt_dly[i] = 0;
      rv_dly[i] = 1;
    end
    resp_idx = 0; stall_err = 0; data_fixed = 0; spur_rv = 0; spur_gnt = 0;
  endtask

  // Called at a falling edge; START is sampled at the next rising edge.
  task automatic start_seq(input logic [ADDR_W-1:0] base, input logic [4:0] sh);
    bus.START = 1'b1;
    bus.BASE_ADDR = base;
    bus.SHAMT_CFG = sh;
    start_ref = cyc;
    @(negedge clk);
    bus.START = 1'b0;
    bus.BASE_ADDR = ADDR_W'($urandom());
    bus.SHAMT_CFG = 5'($urandom());
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.DONE === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.START = 1'b0; bus.BASE_ADDR = 10'h155; bus.SHAMT_CFG = 5'd9;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.WM_REQ !== 1'b0) begin errors++; $display("FAIL reset_wm_req: got %b expected 0", bus.WM_REQ); end
    checks++; if (bus.WM_ADDR !== '0) begin errors++; $display("FAIL reset_wm_addr: got %0h expected 0", bus.WM_ADDR); end
    checks++; if (bus.WLoad1 !== 1'b0) begin errors++; $display("FAIL reset_wload: got %b expected 0", bus.WLoad1); end
    checks++; if (bus.WDATA1 !== '0) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", bus.WDATA1); end
    checks++; if (bus.shamt1 !== '0) begin errors++; $display("FAIL reset_shamt: got %0h expected 0", bus.shamt1); end
    checks++; if (bus.WROW1 !== '0) begin errors++; $display("FAIL reset_wrow: got %0h expected 0", bus.WROW1); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.BUSY); end
    checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.DONE); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({bus.WM_REQ, bus.BUSY, bus.WLoad1} !== 3'b000) begin
      errors++; $display("FAIL reset_idle_after_release: got req/busy/wload=%b expected 000", {bus.WM_REQ, bus.BUSY, bus.WLoad1});
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [ADDR_W-1:0] ea;
    clear_obs();
    data_fixed = 1;
    start_seq(10'h040, 5'd7);
    wait_done(100, ok);
    repeat (3) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done_seen: got none expected DONE within 100 cycles"); end
    checks++; if (gnt_addr_q.size() != ROWS) begin errors++; $display("FAIL basic_req_count: got %0d expected %0d", gnt_addr_q.size(), ROWS); end
    for (int k = 0; k < gnt_addr_q.size() && k < ROWS; k++) begin
      ea = 10'h040 + ADDR_W'(k * STRIDE);
      checks++; if (gnt_addr_q[k] !== ea) begin errors++; $display("FAIL basic_addr%0d: got %0h expected %0h", k, gnt_addr_q[k], ea); end
    end
    checks++; if (ld_row_q.size() != ROWS) begin errors++; $display("FAIL basic_load_count: got %0d expected %0d", ld_row_q.size(), ROWS); end
    for (int k = 0; k < ld_row_q.size() && k < ROWS; k++) begin
      checks++;
      if (ld_row_q[k] !== 2'(k) || ld_data_q[k] !== 32'hA0 + 32'(k) || ld_shamt_q[k] !== 5'd7 || ld_rel_q[k] != 3 + 2 * k) begin
        errors++;
        $display("FAIL basic_load%0d: got row=%0d data=%0h shamt=%0d cycle=%0d expected row=%0d data=%0h shamt=7 cycle=%0d",
                 k, ld_row_q[k], ld_data_q[k], ld_shamt_q[k], ld_rel_q[k], k, 32'hA0 + 32'(k), 3 + 2 * k);
      end
    end
    checks++; if (done_rel_q.size() != 1 || done_rel_q[0] != 9) begin
      errors++; $display("FAIL basic_done_cycle: got count=%0d first=%0d expected count=1 cycle=9", done_rel_q.size(), (done_rel_q.size() > 0) ? done_rel_q[0] : -1);
    end
    for (int c = 1; c <= 10; c++) begin
      checks++; if (busy_arr[c] !== ((c >= 1 && c <= 8) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL basic_busy_cycle%0d: got %b expected %b", c, busy_arr[c], (c <= 8) ? 1'b1 : 1'b0);
      end
    end
    checks++; if (bus.WDATA1 !== 32'hA3 || bus.WROW1 !== 2'd3 || bus.shamt1 !== 5'd7 || bus.WLoad1 !== 1'b0) begin
      errors++; $display("FAIL basic_hold: got data=%0h row=%0d shamt=%0d wload=%b expected a3 3 7 0", bus.WDATA1, bus.WROW1, bus.shamt1, bus.WLoad1);
    end
  endtask

  task automatic test_stalls();
    bit ok;
    logic [ADDR_W-1:0] base, ea;
    logic [4:0] sh;
    clear_obs();
    gnt_dly[1] = 3;
    rv_dly[2] = 4;
    base = ADDR_W'($urandom_range(0, 1023));
    sh = 5'($urandom_range(0, 31));
    start_seq(base, sh);
    wait_done(200, ok);
    repeat (6) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL stall_done_seen: got none expected DONE within 200 cycles"); end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL stall_req_stable: got %0d unstable cycles expected 0", stall_err); end
    checks++; if (gnt_addr_q.size() != ROWS || bus.WM_REQ !== 1'b0) begin
      errors++; $display("FAIL stall_req_count: got %0d grants req=%b expected %0d grants req=0", gnt_addr_q.size(), bus.WM_REQ, ROWS);
    end
    for (int k = 0; k < gnt_addr_q.size() && k < ROWS; k++) begin
      ea = base + ADDR_W'(k * STRIDE);
      checks++; if (gnt_addr_q[k] !== ea) begin errors++; $display("FAIL stall_addr%0d: got %0h expected %0h", k, gnt_addr_q[k], ea); end
    end
    checks++; if (ld_row_q.size() != ROWS) begin errors++; $display("FAIL stall_load_count: got %0d expected %0d", ld_row_q.size(), ROWS); end
    for (int k = 0; k < ld_row_q.size() && k < ROWS && k < exp_q.size(); k++) begin
      checks++;
      if (ld_row_q[k] !== 2'(k) || ld_data_q[k] !== exp_q[k] || ld_shamt_q[k] !== sh || ld_rel_q[k] != rv_rel_q[k] + 1) begin
        errors++;
        $display("FAIL stall_load%0d: got row=%0d data=%0h shamt=%0d cycle=%0d expected row=%0d data=%0h shamt=%0d cycle=%0d",
                 k, ld_row_q[k], ld_data_q[k], ld_shamt_q[k], ld_rel_q[k], k, exp_q[k], sh, rv_rel_q[k] + 1);
      end
    end
    checks++; if (done_rel_q.size() != 1 || ld_rel_q.size() == 0 || done_rel_q[0] != ld_rel_q[ld_rel_q.size() - 1]) begin
      errors++; $display("FAIL stall_done_with_last_load: got %0d done pulses expected 1 aligned with final load", done_rel_q.size());
    end
  endtask

  task automatic test_config_isolation();
    bit ok;
    logic [ADDR_W-1:0] ea;
    clear_obs();
    for (int i = 0; i < 4; i++) rv_dly[i] = 2;
    start_seq(10'h040, 5'd7);
    for (int i = 0; i < 50 && ld_row_q.size() == 0; i++) @(negedge clk);
    bus.BASE_ADDR = 10'h100;
    bus.SHAMT_CFG = 5'd3;
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    wait_done(200, ok);
    repeat (4) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL iso_done_seen: got none expected DONE within 200 cycles"); end
    checks++; if (gnt_addr_q.size() != ROWS || ld_row_q.size() != ROWS || done_rel_q.size() != 1) begin
      errors++; $display("FAIL iso_counts: got req=%0d loads=%0d done=%0d expected %0d %0d 1", gnt_addr_q.size(), ld_row_q.size(), done_rel_q.size(), ROWS, ROWS);
    end
    for (int k = 0; k < gnt_addr_q.size() && k < ROWS; k++) begin
      ea = 10'h040 + ADDR_W'(k * STRIDE);
      checks++; if (gnt_addr_q[k] !== ea) begin errors++; $display("FAIL iso_addr%0d: got %0h expected %0h", k, gnt_addr_q[k], ea); end
    end
    for (int k = 0; k < ld_row_q.size() && k < ROWS; k++) begin
      checks++; if (ld_shamt_q[k] !== 5'd7 || ld_row_q[k] !== 2'(k)) begin
        errors++; $display("FAIL iso_load%0d: got shamt=%0d row=%0d expected shamt=7 row=%0d", k, ld_shamt_q[k], ld_row_q[k], k);
      end
    end
    checks++; if (bus.BUSY !== 1'b0 || bus.WM_REQ !== 1'b0) begin
      errors++; $display("FAIL iso_idle_after: got busy=%b req=%b expected 0 0", bus.BUSY, bus.WM_REQ);
    end
  endtask

  task automatic test_spurious();
    bit ok;
    logic [1:0] st0;
    logic [4:0] sh;
    int bad;
    clear_obs();
    st0 = dbg_state;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      spur_rv = 1'($urandom_range(0, 1));
      spur_gnt = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.WM_REQ !== 1'b0 || bus.BUSY !== 1'b0 || dbg_state !== st0) bad++;
    end
    spur_rv = 0; spur_gnt = 0;
    repeat (2) @(negedge clk);
    checks++; if (ld_row_q.size() != 0 || bad != 0) begin
      errors++; $display("FAIL spur_idle: got %0d loads %0d non-idle cycles expected 0 0", ld_row_q.size(), bad);
    end
    gnt_dly[0] = 4;
    sh = 5'($urandom_range(0, 31));
    spur_rv = 1;
    spur_gnt = 1;
    start_seq(ADDR_W'($urandom()), sh);
    repeat (3) @(negedge clk);
    spur_rv = 0;
    wait_done(200, ok);
    spur_gnt = 0;
    repeat (3) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL spur_done_seen: got none expected DONE within 200 cycles"); end
    checks++; if (gnt_addr_q.size() != ROWS || ld_row_q.size() != ROWS) begin
      errors++; $display("FAIL spur_counts: got req=%0d loads=%0d expected %0d %0d", gnt_addr_q.size(), ld_row_q.size(), ROWS, ROWS);
    end
    for (int k = 0; k < ld_row_q.size() && k < ROWS && k < exp_q.size(); k++) begin
      checks++; if (ld_data_q[k] !== exp_q[k] || ld_row_q[k] !== 2'(k) || ld_shamt_q[k] !== sh) begin
        errors++; $display("FAIL spur_load%0d: got data=%0h row=%0d shamt=%0d expected %0h %0d %0d", k, ld_data_q[k], ld_row_q[k], ld_shamt_q[k], exp_q[k], k, sh);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    logic [4:0] sh1, sh2;
    logic [ADDR_W-1:0] ea;
    clear_obs();
    sh1 = 5'($urandom_range(0, 31));
    sh2 = 5'($urandom_range(0, 31));
    start_seq(ADDR_W'($urandom()), sh1);
    wait_done(100, ok1);
    bus.START = 1'b1;
    bus.BASE_ADDR = 10'h3FE;
    bus.SHAMT_CFG = sh2;
    start_ref = cyc;
    @(negedge clk);
    bus.START = 1'b0;
    wait_done(100, ok2);
    repeat (3) @(negedge clk);
    checks++; if (!ok1 || !ok2) begin errors++; $display("FAIL b2b_done_seen: got first=%b second=%b expected 1 1", ok1, ok2); end
    checks++; if (done_rel_q.size() != 2 || done_rel_q[0] != 9 || done_rel_q[1] != 9) begin
      errors++; $display("FAIL b2b_done_cycles: got %0d pulses expected 2 at cycle 9 of each sequence", done_rel_q.size());
    end
    checks++; if (gnt_addr_q.size() != 2 * ROWS || ld_row_q.size() != 2 * ROWS) begin
      errors++; $display("FAIL b2b_counts: got req=%0d loads=%0d expected %0d %0d", gnt_addr_q.size(), ld_row_q.size(), 2 * ROWS, 2 * ROWS);
    end
    for (int k = 0; k < ROWS && ROWS + k < gnt_addr_q.size(); k++) begin
      ea = 10'h3FE + ADDR_W'(k * STRIDE);
      checks++; if (gnt_addr_q[ROWS + k] !== ea) begin errors++; $display("FAIL b2b_addr%0d: got %0h expected %0h", k, gnt_addr_q[ROWS + k], ea); end
    end
    for (int k = 0; k < ROWS && ROWS + k < ld_row_q.size() && ROWS + k < exp_q.size(); k++) begin
      checks++;
      if (ld_row_q[ROWS + k] !== 2'(k) || ld_data_q[ROWS + k] !== exp_q[ROWS + k] || ld_shamt_q[ROWS + k] !== sh2 || ld_rel_q[ROWS + k] != 3 + 2 * k) begin
        errors++;
        $display("FAIL b2b_load%0d: got row=%0d data=%0h shamt=%0d cycle=%0d expected %0d %0h %0d %0d",
                 k, ld_row_q[ROWS + k], ld_data_q[ROWS + k], ld_shamt_q[ROWS + k], ld_rel_q[ROWS + k], k, exp_q[ROWS + k], sh2, 3 + 2 * k);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int nload;
    logic [4:0] sh;
    logic [ADDR_W-1:0] base, ea;
    clear_obs();
    rv_dly[2] = 6;
    start_seq(ADDR_W'($urandom()), 5'd12);
    for (int i = 0; i < 50 && gnt_addr_q.size() < 3; i++) @(negedge clk);
    @(negedge clk);
    nload = ld_row_q.size();
    checks++; if (nload != 2 || bus.BUSY !== 1'b1) begin
      errors++; $display("FAIL rstmid_before: got loads=%0d busy=%b expected 2 1", nload, bus.BUSY);
    end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.WM_REQ, bus.WM_ADDR, bus.WLoad1, bus.WDATA1, bus.shamt1, bus.WROW1, bus.BUSY, bus.DONE} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got req=%b addr=%0h wload=%b data=%0h shamt=%0h row=%0h busy=%b done=%b expected all 0",
                         bus.WM_REQ, bus.WM_ADDR, bus.WLoad1, bus.WDATA1, bus.shamt1, bus.WROW1, bus.BUSY, bus.DONE);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (ld_row_q.size() != nload || bus.BUSY !== 1'b0 || bus.WM_REQ !== 1'b0 || rv_pend) begin
      errors++; $display("FAIL rstmid_late_rvalid: got loads=%0d busy=%b req=%b expected %0d 0 0", ld_row_q.size(), bus.BUSY, bus.WM_REQ, nload);
    end
    clear_obs();
    base = ADDR_W'($urandom());
    sh = 5'($urandom_range(0, 31));
    start_seq(base, sh);
    wait_done(100, ok);
    repeat (2) @(negedge clk);
    checks++; if (!ok || ld_row_q.size() != ROWS || gnt_addr_q.size() != ROWS) begin
      errors++; $display("FAIL rstmid_fresh_counts: got done=%b loads=%0d req=%0d expected 1 %0d %0d", ok, ld_row_q.size(), gnt_addr_q.size(), ROWS, ROWS);
    end
    for (int k = 0; k < ROWS && k < gnt_addr_q.size() && k < ld_row_q.size() && k < exp_q.size(); k++) begin
      ea = base + ADDR_W'(k * STRIDE);
      checks++;
      if (gnt_addr_q[k] !== ea || ld_row_q[k] !== 2'(k) || ld_data_q[k] !== exp_q[k] || ld_shamt_q[k] !== sh || ld_rel_q[k] != 3 + 2 * k) begin
        errors++;
        $display("FAIL rstmid_fresh%0d: got addr=%0h row=%0d data=%0h shamt=%0d cycle=%0d expected %0h %0d %0h %0d %0d",
                 k, gnt_addr_q[k], ld_row_q[k], ld_data_q[k], ld_shamt_q[k], ld_rel_q[k], ea, k, exp_q[k], sh, 3 + 2 * k);
      end
    end
  endtask

  initial begin
    clear_obs();
    bus.START = 1'b0;
    bus.BASE_ADDR = '0;
    bus.SHAMT_CFG = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_stalls();
    test_config_isolation();
    test_spurious();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/weight_load_ctrl.md
Name: weight_load_ctrl

Overview:
- Sequencer that fetches one weight row per memory transaction from the shared weight memory and drives the weight-load pipeline register (WLoad1/WDATA1/shamt1/WROW1 inputs) that feeds the MAC array.
- On START it issues ROWS read requests, one outstanding at a time, over a request/grant port, and forwards each returned word as a one-cycle weight-load pulse tagged with its row index and the layer shift amount.
- Signals completion with DONE.

Parameters:
- ADDR_W, 10, weight memory address width.
- ROWS, 4, rows loaded per START; legal range 1..4 (WROW is 2 bits).
- STRIDE, 1, address increment between consecutive rows.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- START  in  1  begin a weight-load sequence; sampled only in IDLE.
- BASE_ADDR  in  ADDR_W  address of row 0; latched on accepted START.
- SHAMT_CFG  in  5  layer shift amount; latched on accepted START.
- WM_REQ  out  1  memory read request.
- WM_ADDR  out  ADDR_W  read address; valid while WM_REQ=1.
- WM_GNT  in  1  grant; transfer accepted when WM_REQ & WM_GNT.
- WM_RVALID  in  1  read data valid; earliest one cycle after grant.
- WM_RDATA  in  32  read data.
- WLoad1  out  1  weight-load strobe to the pipeline register.
- WDATA1  out  32  weight word.
- shamt1  out  5  shift amount for this load.
- WROW1  out  2  target row index.
- BUSY  out  1  high whenever state != IDLE.
- DONE  out  1  one-cycle pulse coinciding with the final WLoad1.

Behaviour:
- All outputs registered.
- Reset (async assert, any state, including mid-sequence): state=IDLE; WM_REQ=0, WM_ADDR=0, WLoad1=0, WDATA1=0, shamt1=0, WROW1=0, BUSY=0, DONE=0; row counter=0. Any in-flight transaction is abandoned.
- States: IDLE, REQ, WAIT.
- IDLE:
  - START=1 -> REQ.
  - Latch base = BASE_ADDR and shamt = SHAMT_CFG; row=0.
  - WM_REQ=1 and WM_ADDR=BASE_ADDR appear the next cycle.
- REQ:
  - WM_REQ held high with WM_ADDR stable until WM_GNT=1.
  - On grant -> WAIT; WM_REQ deasserts the next cycle.
- WAIT:
  - WM_RVALID=1 -> next cycle WLoad1=1, WDATA1=WM_RDATA, WROW1=row[1:0], shamt1=latched shamt.
  - If row < ROWS-1: row++, -> REQ with WM_ADDR = base + row*STRIDE (row = new value); WM_REQ high in the same cycle as WLoad1.
  - If row = ROWS-1: -> IDLE; DONE=1 and BUSY=0 in the same cycle as the final WLoad1.
- WLoad1 and DONE are single-cycle pulses. WDATA1, WROW1 and shamt1 hold their last values while WLoad1=0.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is permitted, not flagged.
- Ignored inputs:
  - START outside IDLE (no effect on latched config).
  - WM_GNT while WM_REQ=0.
  - WM_RVALID outside WAIT.
- START is accepted in the cycle DONE is high, since the state is already IDLE. The new sequence runs back-to-back with no dead cycle beyond the REQ setup.
- Minimum timing, grant same cycle as REQ and RVALID one cycle after grant, START sampled at edge 0:
  - WM_REQ high from cycle 1.
  - Row k WLoad1 in cycle 3+2k.
  - With ROWS=4, DONE in cycle 9.
- shamt and base are constant for the whole sequence regardless of input changes.

Test Plan:
- Basic load: ROWS=4, BASE_ADDR=0x040, SHAMT_CFG=7, grant immediate, RVALID 1 cycle after grant, RDATA=0xA0+row -> WM_ADDR 0x040..0x043; WLoad1 pulses in cycles 3,5,7,9 with WROW1 0,1,2,3, WDATA1 0xA0..0xA3, shamt1=7; DONE=1 only in cycle 9; BUSY high cycles 1-8.
- Grant and read stalls: WM_GNT delayed 3 cycles for row 1, RVALID delayed 4 cycles for row 2 -> WM_REQ/WM_ADDR stable through the stall; exactly 4 WLoad1 pulses in row order; no extra requests.
- Config isolation: change SHAMT_CFG to 3 and BASE_ADDR to 0x100, and pulse START, mid-sequence -> ignored; all remaining loads keep shamt1=7 and original addresses.
- Spurious inputs: WM_RVALID pulses in IDLE and REQ, WM_GNT with WM_REQ=0 -> no WLoad1, no state change.
- Back-to-back: START asserted in the DONE cycle with BASE_ADDR=0x3FE, ROWS=4 -> second sequence addresses 0x3FE, 0x3FF, 0x000, 0x001 (wrap); DONE pulses again.
- Reset mid-operation: RSTN low while in WAIT for row 2 -> outputs immediately 0, IDLE; late RVALID after release ignored; fresh START runs a full clean sequence from row 0.
